serial_rx_ctrl: RTL
===================

Name: serial_rx_ctrl

Overview:
- Receive-side frame controller, the counterpart of the serial TX controller on the far end of the link.
- Consumes bytes from the UART byte receiver (`byte_in` plus `rx_done`) and reassembles big-endian 16-bit words, each with a word index.
- Runs CRC-16 over the data bytes and checks it against the trailing CRC bytes (hi byte first).
- Reports the frame as accepted, CRC-failed, aborted or timed out.

Parameters:
- n_word, 8'h01, data words per frame; valid 1..255; 0 behaves as 256.
- timeout_cycles, 16'd50000, maximum clk cycles allowed between accepted bytes inside a frame.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- byte_in  in  8  received byte; valid when rx_done rises.
- rx_done  in  1  byte-received level/strobe from UART RX; only its rising edge is used.
- rx_err  in  1  UART framing/parity error, sampled each cycle.
- data_out  out  16  assembled word {hi, lo}.
- data_select  out  8  word index 0..n_word-1; valid with data_wr.
- data_wr  out  1  one-cycle word write strobe.
- frame_ok  out  1  one-cycle pulse: CRC matched, frame committed.
- crc_err  out  1  one-cycle pulse: CRC mismatch.
- frame_err  out  1  one-cycle pulse: rx_err aborted a frame.
- timeout_err  out  1  one-cycle pulse: inter-byte gap exceeded.
- busy  out  1  high while not IDLE.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; all outputs 0; crc=16'hFFFF; timeout counter 0.
  - Edge-detect register pre_done=1, so an rx_done held high across reset release is not an edge.
- Byte event:
  - byte_ev = rx_done & ~pre_done; pre_done <= rx_done every cycle.
  - All responses are registered and appear the cycle after the first rx_done=1 cycle (latency 1).
- CRC:
  - CRC-16/MODBUS: reflected poly 16'hA001, init 16'hFFFF, no final XOR.
  - Updated in a single cycle (8 unrolled shifts) for every data byte, hi then lo, in arrival order.
  - CRC bytes themselves are not fed in.
  - crc is reloaded to 16'hFFFF whenever IDLE is entered.
- States:
  - IDLE: busy=0. byte_ev -> latch hi=byte_in, update crc, index=0, go RX_LO.
  - RX_HI: byte_ev -> latch hi, update crc, go RX_LO.
  - RX_LO: byte_ev -> data_out={hi,byte_in}, data_select=index, data_wr=1 for one cycle, update crc.
    - If index==n_word-1 (8-bit compare, so 0 wraps to 255): go CRC_HI.
    - Else: index+1, go RX_HI.
  - CRC_HI: byte_ev -> latch crc_hi, go CRC_LO.
  - CRC_LO: byte_ev -> compare {crc_hi,byte_in} with crc.
    - Equal: frame_ok pulse.
    - Else: crc_err pulse.
    - Either way go IDLE.
- Timeout:
  - Counter runs in every non-IDLE state and clears on each byte_ev.
  - Reaching timeout_cycles -> timeout_err pulse, go IDLE.
- rx_err:
  - In any non-IDLE state: frame_err pulse, go IDLE.
  - In IDLE: ignored, and no frame starts that cycle.
  - Simultaneous rx_err and byte_ev: rx_err wins and the byte is discarded.
  - Timeout and rx_err in the same cycle: only frame_err is asserted.
- Commit rule:
  - Words already strobed via data_wr are provisional; the consumer discards them unless frame_ok follows.
  - Exactly one of frame_ok/crc_err/frame_err/timeout_err ends each started frame.
- Holding outputs:
  - data_out and data_select hold their last value between strobes.
  - All pulse outputs are 0 except their single cycle.
- Reset mid-frame: immediate return to IDLE, no error pulse, partial frame lost.

Test Plan:
- n_word=1, bytes 00,00,B0,01 (clean gaps):
  - data_wr once with data_out=16'h0000, data_select=0.
  - Then frame_ok one cycle after the 4th rx_done rise; crc_err stays 0.
- n_word=1, bytes 00,00,B0,00 -> data_wr once, then crc_err pulse, no frame_ok, busy drops with the pulse.
- n_word=2, bytes 12,34,AB,CD, then correct CRC computed by the bench model:
  - data_wr with (16'h1234, 0), then (16'hABCD, 1).
  - Then frame_ok.
- n_word=2, rx_err asserted in the same cycle as the 3rd rx_done rise:
  - frame_err pulse; 3rd byte discarded; only one data_wr seen.
  - A following valid frame is accepted.
- timeout_cycles=100, send 2 bytes then idle 100 cycles -> timeout_err exactly 100 cycles after the last byte_ev; state IDLE.
- Edge/reset cases:
  - rx_done held high for 5 cycles -> counted as one byte.
  - reset pulsed low mid-frame -> all outputs 0 immediately, no error pulse.
  - rx_done high at reset release -> no byte counted.

Source files
------------

// File: rtl/serial_rx_ctrl.sv
// Receive-side frame controller: rebuilds big-endian 16-bit words from UART bytes,
// checks the trailing CRC-16/MODBUS and reports how each frame ended.
module serial_rx_ctrl #(
    parameter logic [7:0]  n_word         = 8'h01,
    parameter logic [15:0] timeout_cycles = 16'd50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  byte_in,
    input  logic        rx_done,
    input  logic        rx_err,
    output logic [15:0] data_out,
    output logic [7:0]  data_select,
    output logic        data_wr,
    output logic        frame_ok,
    output logic        crc_err,
    output logic        frame_err,
    output logic        timeout_err,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE,
        RX_HI,
        RX_LO,
        CRC_HI,
        CRC_LO
    } state_t;

    // Index of the final data word; n_word of 0 wraps to 255, giving 256 words.
    localparam logic [7:0] LAST_IDX = n_word - 8'd1;

    state_t      state_q;
    logic        pre_done_q;
    logic [15:0] crc_q;
    logic [7:0]  hi_q;
    logic [7:0]  crc_hi_q;
    logic [7:0]  index_q;
    logic [15:0] tmo_q;
    logic [15:0] data_out_q;
    logic [7:0]  data_select_q;
    logic        data_wr_q;
    logic        frame_ok_q;
    logic        crc_err_q;
    logic        frame_err_q;
    logic        timeout_err_q;
    logic        busy_q;

    logic        byte_ev;
    logic        tmo_hit;
    logic [15:0] crc_d;

    function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in, input logic [7:0] data);
        logic [15:0] c;
        c = crc_in ^ {8'h00, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        return c;
    endfunction

    assign byte_ev = rx_done & ~pre_done_q;
    assign tmo_hit = ({1'b0, tmo_q} + 17'd1) == {1'b0, timeout_cycles};
    assign crc_d   = crc16_byte(crc_q, byte_in);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            pre_done_q    <= 1'b1;
            crc_q         <= 16'hFFFF;
            hi_q          <= 8'h00;
            crc_hi_q      <= 8'h00;
            index_q       <= 8'h00;
            tmo_q         <= 16'h0000;
            data_out_q    <= 16'h0000;
            data_select_q <= 8'h00;
            data_wr_q     <= 1'b0;
            frame_ok_q    <= 1'b0;
            crc_err_q     <= 1'b0;
            frame_err_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            pre_done_q    <= rx_done;
            data_wr_q     <= 1'b0;
            frame_ok_q    <= 1'b0;
            crc_err_q     <= 1'b0;
            frame_err_q   <= 1'b0;
            timeout_err_q <= 1'b0;

            if (state_q == IDLE) begin
                tmo_q <= 16'h0000;
                // An rx_err in IDLE suppresses a frame start in the same cycle.
                if (byte_ev && !rx_err) begin
                    hi_q    <= byte_in;
                    crc_q   <= crc_d;
                    index_q <= 8'h00;
                    state_q <= RX_LO;
                    busy_q  <= 1'b1;
                end
            end else if (rx_err) begin
                frame_err_q <= 1'b1;
                state_q     <= IDLE;
                busy_q      <= 1'b0;
                crc_q       <= 16'hFFFF;
                tmo_q       <= 16'h0000;
            end else if (byte_ev) begin
                tmo_q <= 16'h0000;
                case (state_q)
                    RX_HI: begin
                        hi_q    <= byte_in;
                        crc_q   <= crc_d;
                        state_q <= RX_LO;
                    end
                    RX_LO: begin
                        data_out_q    <= {hi_q, byte_in};
                        data_select_q <= index_q;
                        data_wr_q     <= 1'b1;
                        crc_q         <= crc_d;
                        if (index_q == LAST_IDX) begin
                            state_q <= CRC_HI;
                        end else begin
                            index_q <= index_q + 8'd1;
                            state_q <= RX_HI;
                        end
                    end
                    CRC_HI: begin
                        crc_hi_q <= byte_in;
                        state_q  <= CRC_LO;
                    end
                    CRC_LO: begin
                        if ({crc_hi_q, byte_in} == crc_q) begin
                            frame_ok_q <= 1'b1;
                        end else begin
                            crc_err_q <= 1'b1;
                        end
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        crc_q   <= 16'hFFFF;
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        crc_q   <= 16'hFFFF;
                    end
                endcase
            end else if (tmo_hit) begin
                timeout_err_q <= 1'b1;
                state_q       <= IDLE;
                busy_q        <= 1'b0;
                crc_q         <= 16'hFFFF;
                tmo_q         <= 16'h0000;
            end else begin
                tmo_q <= tmo_q + 16'd1;
            end
        end
    end

    assign data_out    = data_out_q;
    assign data_select = data_select_q;
    assign data_wr     = data_wr_q;
    assign frame_ok    = frame_ok_q;
    assign crc_err     = crc_err_q;
    assign frame_err   = frame_err_q;
    assign timeout_err = timeout_err_q;
    assign busy        = busy_q;

endmodule
